ram_fifo_ctrl: RTL and testbench

Flow-controlled FIFO controller that drives the write port and consumes the read port of the team's dual-port `ram` (asynchronous read, write on `clk` rising edge when `write_enable` is high). It converts a valid/ready input stream into RAM writes, and RAM reads into a registered valid/ready output stream. The RAM is instantiated alongside it, not inside it. Total buffering is DEPTH RAM entries plus one output-register entry.

---
 rtl/ram_fifo_pkg.sv | 19 +
 rtl/ram.sv | 26 ++
 rtl/ram_fifo_wrap_counter.sv | 22 ++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared parameters, output-register state type and pointer wrap helper for ram_fifo_ctrl
// and the ram instance it drives.
package ram_fifo_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 32;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Wraps at depth-1 so non power-of-two depths address only the usable entries.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/ram.sv
// Dual-port RAM: write on clk rising edge when write_enable is high, asynchronous read.
// Contents are never cleared; the controller never relies on their initial value.
module ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] address_write,
   input  logic [DATA_WIDTH-1:0] data_write,
   input  logic [ADDR_WIDTH-1:0] address_read,
   output logic [DATA_WIDTH-1:0] data_read
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem[address_write] <= data_write;
      end
   end

   assign data_read = mem[address_read];

endmodule

// File: rtl/ram_fifo_wrap_counter.sv
// Pointer counter 0..DEPTH-1: advances by one on inc and wraps DEPTH-1 -> 0.
// Registered value, one edge per increment; no backpressure of its own.
module wrap_counter #(
   parameter int ADDR_WIDTH = ram_fifo_pkg::ADDR_WIDTH,
   parameter int DEPTH      = ram_fifo_pkg::DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] value
);
   import ram_fifo_pkg::*;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (inc) begin
         value <= ADDR_WIDTH'(ptr_next(32'(value), 32'(DEPTH)));
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external RAM plus one output register; 2-edge latency.
// in_ready depends only on registered occupancy, so a same-cycle drain frees space one cycle later.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = ram_fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = ram_fifo_pkg::ADDR_WIDTH,
   parameter int DEPTH      = ram_fifo_pkg::DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] ram_address_write,
   output logic [DATA_WIDTH-1:0] ram_data_write,
   output logic                  ram_write_enable,
   output logic [ADDR_WIDTH-1:0] ram_address_read,
   input  logic [DATA_WIDTH-1:0] ram_data_read
);
   import ram_fifo_pkg::*;

   localparam int                CW        = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]     CNT_DEPTH = CW'(DEPTH);

   logic [CW-1:0]         ram_count;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  accept;
   logic                  load;
   out_state_t            state_q;
   out_state_t            state_d;

   // rst_n gates in_ready so nothing is written to the RAM while reset is held.
   assign in_ready = rst_n && (ram_count != CNT_DEPTH);
   assign accept   = in_valid && in_ready;
   assign load     = (ram_count != '0) && (!out_valid || out_ready);

   assign ram_write_enable  = accept;
   assign ram_address_write = wr_ptr;
   assign ram_data_write    = in_data;
   assign ram_address_read  = rd_ptr;

   assign out_valid = (state_q == OUT_FULL);
   assign count     = ram_count + {{ADDR_WIDTH{1'b0}}, out_valid};

   wrap_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept),
      .value (wr_ptr)
   );

   wrap_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (load),
      .value (rd_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_count <= '0;
      end else begin
         case ({accept, load})
            2'b10:   ram_count <= ram_count + CNT_ONE;
            2'b01:   ram_count <= ram_count - CNT_ONE;
            default: ram_count <= ram_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OUT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OUT_EMPTY: if (load)                state_d = OUT_FULL;
         OUT_FULL:  if (out_ready && !load)  state_d = OUT_EMPTY;
         default:                            state_d = OUT_EMPTY;
      endcase
   end

   // out_data keeps the last word after it is consumed; only a load replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
      end else if (load) begin
         out_data <= ram_data_read;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with its ram: directed vector table, fill/stream/drain sequences,
// random traffic against a queue model, and a mid-stream reset.
module tb_ram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW:0]   count;
   logic [AW-1:0] ram_address_write;
   logic [DW-1:0] ram_data_write;
   logic          ram_write_enable;
   logic [AW-1:0] ram_address_read;
   logic [DW-1:0] ram_data_read;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .count             (count),
      .ram_address_write (ram_address_write),
      .ram_data_write    (ram_data_write),
      .ram_write_enable  (ram_write_enable),
      .ram_address_read  (ram_address_read),
      .ram_data_read     (ram_data_read)
   );

   ram #(DW, AW, DEPTH) u_ram (
      .clk           (clk),
      .write_enable  (ram_write_enable),
      .address_write (ram_address_write),
      .data_write    (ram_data_write),
      .address_read  (ram_address_read),
      .data_read     (ram_data_read)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO of words in RAM, plus the output register.
   logic [DW-1:0] mq[$];
   bit            mv;
   logic [DW-1:0] md;
   int            wr_n;
   int            rd_n;

   task automatic model_reset();
      mq.delete();
      mv   = 1'b0;
      md   = '0;
      wr_n = 0;
      rd_n = 0;
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".in_ready"},  int'(in_ready),  int'(mq.size() != DEPTH));
      chk({tag, ".we"},        int'(ram_write_enable), int'(in_valid && mq.size() != DEPTH));
      chk({tag, ".out_valid"}, int'(out_valid), int'(mv));
      chk({tag, ".out_data"},  int'(out_data),  int'(md));
      chk({tag, ".count"},     int'(count),     mq.size() + int'(mv));
      chk({tag, ".waddr"},     int'(ram_address_write), wr_n % DEPTH);
      chk({tag, ".raddr"},     int'(ram_address_read),  rd_n % DEPTH);
   endtask

   task automatic model_step();
      bit acc;
      bit ld;
      acc = in_valid && (mq.size() != DEPTH);
      ld  = (mq.size() != 0) && (!mv || out_ready);
      if (ld) begin
         md = mq.pop_front();
         mv = 1'b1;
         rd_n++;
      end else if (mv && out_ready) begin
         mv = 1'b0;
      end
      if (acc) begin
         mq.push_back(in_data);
         wr_n++;
      end
   endtask

   // One clock: inputs already driven; check at negedge, advance model, return at posedge+1.
   task automatic cycle(input string tag, output bit we_s, output bit pop_s, output logic [DW-1:0] pd);
      @(negedge clk);
      we_s  = ram_write_enable;
      pop_s = out_valid && out_ready;
      pd    = out_data;
      model_check(tag);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      out_ready = 1'b0;
      #1;
      chk("rst.in_ready",  int'(in_ready), 0);
      chk("rst.we",        int'(ram_write_enable), 0);
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.out_data",  int'(out_data), 0);
      chk("rst.count",     int'(count), 0);
      chk("rst.waddr",     int'(ram_address_write), 0);
      chk("rst.raddr",     int'(ram_address_read), 0);
      in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          iv;
      logic [7:0]  d;
      bit          ordy;
      bit          e_we;
      bit          e_ir;
      bit          e_ov;
      logic [7:0]  e_od;
      int          e_cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      bit            we_s;
      bit            pop_s;
      logic [DW-1:0] pd;
      int            acc_cnt;
      int            rx;
      int            nxt;
      bit            seen;

      vecs[0] = '{1'b1, 8'hC5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC5, 1};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC5, 1};
      vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC5, 0};
      vecs[5] = '{1'b1, 8'h4D, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC5, 1};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 2};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4D, 1};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 0};

      do_reset();

      // Directed vector table.
      for (int i = 0; i < 9; i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         out_ready = vecs[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d.we", i),        int'(ram_write_enable), int'(vecs[i].e_we));
         chk($sformatf("vec%0d.in_ready", i),  int'(in_ready),  int'(vecs[i].e_ir));
         chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
         chk($sformatf("vec%0d.out_data", i),  int'(out_data),  int'(vecs[i].e_od));
         chk($sformatf("vec%0d.count", i),     int'(count),     vecs[i].e_cnt);
         if (i == 0) chk("vec0.waddr", int'(ram_address_write), 0);
         @(posedge clk);
         #1;
      end

      // Fill with consumer stalled: exactly DEPTH+1 words fit.
      do_reset();
      acc_cnt = 0;
      for (int c = 0; c < 50; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(acc_cnt);
         cycle("fill", we_s, pop_s, pd);
         if (we_s) acc_cnt++;
      end
      chk("fill.accepts",  acc_cnt, DEPTH + 1);
      chk("fill.count",    int'(count), DEPTH + 1);
      chk("fill.in_ready", int'(in_ready), 0);
      chk("fill.out_data", int'(out_data), 8'h00);

      // One-cycle drain while full: no write that cycle, one write the next.
      in_valid  = 1'b1;
      in_data   = 8'h55;
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain.in_ready", int'(in_ready), 0);
      chk("drain.we",       int'(ram_write_enable), 0);
      model_step();
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_data   = 8'h66;
      @(negedge clk);
      chk("refill.in_ready", int'(in_ready), 1);
      chk("refill.we",       int'(ram_write_enable), 1);
      model_step();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("refill.count",    int'(count), DEPTH + 1);
      chk("refill.in_ready", int'(in_ready), 0);
      chk("refill.out_data", int'(out_data), 8'h01);

      // Streaming: 100 words, one per cycle after a 2-cycle fill, pointers wrap.
      do_reset();
      out_ready = 1'b1;
      nxt = 1;
      rx  = 0;
      for (int c = 0; c < 200 && rx < 100; c++) begin
         in_valid = (nxt <= 100);
         in_data  = 8'(nxt);
         cycle("stream", we_s, pop_s, pd);
         if (we_s) nxt++;
         if (pop_s) begin
            chk($sformatf("stream.data%0d", rx), int'(pd), rx + 1);
            chk($sformatf("stream.cyc%0d", rx), c, rx + 2);
            rx++;
         end
      end
      chk("stream.received", rx, 100);

      // Random traffic against the model; phases bias toward full then empty.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if (c < 1000) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) == 0;
         end else begin
            in_valid  = ($urandom % 3) == 0;
            out_ready = ($urandom % 4) != 0;
         end
         in_data = 8'($urandom);
         cycle("rand", we_s, pop_s, pd);
      end

      // Reset mid-stream discards contents immediately.
      do_reset();
      acc_cnt = 0;
      for (int c = 0; c < 30 && acc_cnt < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 + acc_cnt);
         cycle("pre", we_s, pop_s, pd);
         if (we_s) acc_cnt++;
      end
      in_valid = 1'b0;
      chk("mid.count_before", int'(count), 10);
      in_valid = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk("mid.out_valid", int'(out_valid), 0);
      chk("mid.count",     int'(count), 0);
      chk("mid.in_ready",  int'(in_ready), 0);
      chk("mid.we",        int'(ram_write_enable), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      cycle("post", we_s, pop_s, pd);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            chk("post.first", int'(out_data), 8'hA5);
         end
         @(posedge clk);
         #1;
      end
      if (!seen) chk("post.timeout", 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
